ins_fetch_queue: RTL and testbench
==================================

Name: ins_fetch_queue

Overview:
Parametrised instruction fetch unit that replaces the single-word instruction buffer.
- Holds a writable instruction memory of DEPTH words, addressed relative to a programmable base address.
- Prefetches sequential instructions into a FIFO_DEPTH-entry queue.
- Delivers {pc, instruction, fault} to decode over a valid/ready handshake.
- Supports redirect (branch/jump) with queue flush, and flags out-of-range or misaligned fetches instead of silently substituting NOPs.

Parameters:
- DEPTH, 128, instruction memory words; power of two, at least 2.
- FIFO_DEPTH, 4, prefetch queue entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, value loaded into fetch_pc and base on reset.
- NOP_INS, 32'h0000_0013, instruction word emitted with fault entries and the initial memory fill value.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- redirect_valid  in  1  flush the queue and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address.
- base_we  in  1  load a new memory base address.
- base_in  in  32  base address value.
- prog_we  in  1  memory write enable.
- prog_addr  in  $clog2(DEPTH)  memory word index.
- prog_data  in  32  memory write data.
- out_valid  out  1  queue head is valid.
- out_ready  in  1  decode accepts the head entry.
- out_ins  out  32  head instruction.
- out_pc  out  32  head PC.
- out_fault  out  1  head entry is a fetch fault.
- fetch_halted  out  1  fetch stopped after a fault.

Behaviour:
Reset (priority 1):
- fetch_pc=RESET_PC, base=RESET_PC, queue emptied (count=0), state FETCH.
- out_valid=0, out_ins=NOP_INS, out_pc=0, out_fault=0, fetch_halted=0.
- Memory contents are not cleared by reset. Initial content is NOP_INS in every word.

Fetch address and fault rules:
- offset = fetch_pc - base, 32-bit modulo arithmetic; idx = offset[31:2].
- Fault when offset[1:0]!=0 or idx>=DEPTH. A fault entry carries ins=NOP_INS and fault=1.
- Memory read is combinational on idx.

Queue signals:
- pop = out_valid && out_ready.
- can_push = (count<FIFO_DEPTH) || pop.

State FETCH:
- Each cycle with can_push and no redirect, push {fetch_pc, mem[idx] or NOP_INS, fault} and set fetch_pc += 4.
- A pushed fault entry moves the state to HALT. fetch_pc does not increment on a fault push.
- Sustained throughput is one instruction per cycle.

State HALT:
- No pushes. fetch_halted=1. Queued entries continue to drain normally.
- Only a redirect or reset leaves HALT.

Redirect (priority 2, cycle T):
- Queue emptied at the T edge; a pop in cycle T is discarded.
- fetch_pc=redirect_pc, state FETCH. No push occurs in cycle T.
- Cycle T+1: out_valid=0, and the first new entry is pushed.
- Cycle T+2: out_valid=1, out_pc=redirect_pc.

base_we:
- base updates at the edge; does not flush the queue.
- Fetches from the next cycle onward use the new base.
- base_we together with redirect_valid: both take effect.

prog_we:
- Write at the edge.
- A fetch of the same idx in the same cycle captures the old data.
- Writes do not disturb queue contents.

Queue structure and outputs:
- Circular buffer with read/write pointers and a count of width $clog2(FIFO_DEPTH)+1.
- Pointers wrap modulo FIFO_DEPTH.
- Push and pop in the same cycle while full are both performed; count is unchanged.
- Outputs are driven from the head entry (registered storage, no combinational path from out_ready).
- While out_valid=0: out_ins=NOP_INS, out_pc=0, out_fault=0.
- Head entry is held stable while out_valid && !out_ready.

Fetch address wrap:
- fetch_pc wraps modulo 2^32. The fault rule covers running past the top of memory.

Test Plan:
- Reset, load mem[0..3]=00208233,403082B3,0020F333,0030E3B3, out_ready=1 -> out_valid rises at cycle 2 after reset release; out_pc=0,4,8,C on consecutive cycles with matching out_ins; out_fault=0.
- out_ready=0 for 10 cycles after reset -> count saturates at 4; head holds pc=0. Release out_ready -> pcs 0,4,8,C,10 back-to-back with no duplicates or gaps.
- Redirect to 0x20 while the queue holds 3 entries and out_ready=1 -> out_valid=0 at T+1; out_pc=0x20 at T+2, then 0x24. No pre-redirect pc appears after T.
- base_we with base_in=0x1000 followed by redirect to 0x11FC (idx 127) -> entry pc=0x11FC valid; next entry pc=0x1200 has out_fault=1 and out_ins=00000013; fetch_halted=1 and no further entries.
- Redirect to 0x1002 (misaligned) -> single fault entry with pc=0x1002; halt. A subsequent redirect to 0x1000 clears fetch_halted and resumes normal fetch.
- prog_we to idx 5 in the same cycle the fetch reads idx 5 -> old word is delivered. A later redirect to pc 0x14 (base 0) delivers the new word. Asserting rst mid-stream -> out_valid=0 next cycle, and memory retains the written word.

Source files
------------

// File: rtl/ins_fetch_queue.sv
// Instruction fetch unit: program memory, prefetch queue, redirect.
// Out-of-range or misaligned fetches become fault entries and halt fetch.
module ins_fetch_queue #(
    parameter int          DEPTH      = 128,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INS    = 32'h0000_0013
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    input  logic                     base_we,
    input  logic [31:0]              base_in,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [31:0]              prog_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_ins,
    output logic [31:0]              out_pc,
    output logic                     out_fault,
    output logic                     fetch_halted
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HALT  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [31:0]   r_mem [DEPTH] = '{default: NOP_INS};
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_base;

    logic [31:0]   r_q_pc    [FIFO_DEPTH];
    logic [31:0]   r_q_ins   [FIFO_DEPTH];
    logic          r_q_fault [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic [31:0]   w_offset;
    logic [AW-1:0] w_idx;
    logic          w_fault;
    logic [31:0]   w_ins;
    logic          w_valid;
    logic          w_pop;
    logic          w_can_push;
    logic          w_push;

    assign w_offset   = r_fetch_pc - r_base;
    assign w_idx      = w_offset[AW+1:2];
    assign w_fault    = (w_offset[1:0] != 2'b00) ||
                        (w_offset[31:AW+2] != '0);
    assign w_ins      = w_fault ? NOP_INS : r_mem[w_idx];

    assign w_valid    = (r_count != '0);
    assign w_pop      = w_valid && out_ready;
    assign w_can_push = (r_count < FULL) || w_pop;
    assign w_push     = (r_state == S_FETCH) && w_can_push &&
                        !redirect_valid;

    assign out_valid    = w_valid;
    assign out_ins      = w_valid ? r_q_ins[r_rptr] : NOP_INS;
    assign out_pc       = w_valid ? r_q_pc[r_rptr] : 32'h0;
    assign out_fault    = w_valid && r_q_fault[r_rptr];
    assign fetch_halted = (r_state == S_HALT);

    // Program memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    // Fetch state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a pushed fault halts, only redirect resumes.
    always_comb begin
        w_state_nxt = r_state;
        if (redirect_valid) begin
            w_state_nxt = S_FETCH;
        end else if (w_push && w_fault) begin
            w_state_nxt = S_HALT;
        end
    end

    // Fetch PC and memory base.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_base     <= RESET_PC;
        end else begin
            if (base_we) begin
                r_base <= base_in;
            end
            if (redirect_valid) begin
                r_fetch_pc <= redirect_pc;
            end else if (w_push && !w_fault) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
        end
    end

    // Queue payload storage; written only on push.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_wptr]    <= r_fetch_pc;
            r_q_ins[r_wptr]   <= w_ins;
            r_q_fault[r_wptr] <= w_fault;
        end
    end

    // Queue pointers and occupancy; redirect flushes.
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ins_fetch_queue.sv
// Directed bench for ins_fetch_queue.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_ins_fetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        base_we;
    logic [31:0] base_in;
    logic        prog_we;
    logic [6:0]  prog_addr;
    logic [31:0] prog_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ins;
    logic [31:0] out_pc;
    logic        out_fault;
    logic        fetch_halted;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] prog_words [4];

    ins_fetch_queue dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .base_we        (base_we),
        .base_in        (base_in),
        .prog_we        (prog_we),
        .prog_addr      (prog_addr),
        .prog_data      (prog_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_ins        (out_ins),
        .out_pc         (out_pc),
        .out_fault      (out_fault),
        .fetch_halted   (fetch_halted)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        prog_words[0] = 32'h0020_8233;
        prog_words[1] = 32'h4030_82B3;
        prog_words[2] = 32'h0020_F333;
        prog_words[3] = 32'h0030_E3B3;

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        base_we        = 1'b0;
        base_in        = '0;
        prog_we        = 1'b0;
        prog_addr      = '0;
        prog_data      = '0;
        out_ready      = 1'b1;

        // Load program while held in reset
        for (int i = 0; i < 4; i++) begin
            prog_we   = 1'b1;
            prog_addr = 7'(i);
            prog_data = prog_words[i];
            step();
        end
        prog_we = 1'b0;
        step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ins", out_ins, NOP);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_fault", 32'(out_fault), 32'd0);
        chk("rst_halt", 32'(fetch_halted), 32'd0);

        // Streaming from reset, one per cycle
        rst = 1'b0;
        chk("c1_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("str_valid", 32'(out_valid), 32'd1);
            chk("str_pc", out_pc, 32'(4 * i));
            chk("str_ins", out_ins, prog_words[i]);
            chk("str_fault", 32'(out_fault), 32'd0);
        end

        // Backpressure: queue fills, head holds
        rst = 1'b1;
        step();
        rst       = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) step();
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_pc", out_pc, 32'h0);
        chk("bp_ins", out_ins, prog_words[0]);
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("bp_drain_pc", out_pc, 32'(4 * i));
            chk("bp_drain_v", 32'(out_valid), 32'd1);
        end
        chk("bp_ins_14", out_ins, NOP);

        // Redirect with three queued entries
        rst = 1'b1;
        step();
        rst       = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        step();
        chk("rd_pre_pc", out_pc, 32'h0);
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        step();
        redirect_valid = 1'b0;
        chk("rd_t1_valid", 32'(out_valid), 32'd0);
        step();
        chk("rd_t2_valid", 32'(out_valid), 32'd1);
        chk("rd_t2_pc", out_pc, 32'h20);
        chk("rd_t2_ins", out_ins, NOP);
        step();
        chk("rd_t3_pc", out_pc, 32'h24);

        // Run off the top of memory under base 0x1000
        base_we = 1'b1;
        base_in = 32'h1000;
        step();
        base_we        = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h11FC;
        step();
        redirect_valid = 1'b0;
        chk("top_t1_valid", 32'(out_valid), 32'd0);
        step();
        chk("top_pc", out_pc, 32'h11FC);
        chk("top_fault", 32'(out_fault), 32'd0);
        step();
        chk("oob_pc", out_pc, 32'h1200);
        chk("oob_valid", 32'(out_valid), 32'd1);
        chk("oob_fault", 32'(out_fault), 32'd1);
        chk("oob_ins", out_ins, NOP);
        chk("oob_halt", 32'(fetch_halted), 32'd1);
        step();
        chk("halt_empty", 32'(out_valid), 32'd0);
        chk("halt_hold", 32'(fetch_halted), 32'd1);
        step();
        chk("halt_empty2", 32'(out_valid), 32'd0);

        // Misaligned redirect, then recovery
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1002;
        step();
        redirect_valid = 1'b0;
        chk("mis_unhalt", 32'(fetch_halted), 32'd0);
        chk("mis_t1_valid", 32'(out_valid), 32'd0);
        step();
        chk("mis_pc", out_pc, 32'h1002);
        chk("mis_fault", 32'(out_fault), 32'd1);
        chk("mis_halt", 32'(fetch_halted), 32'd1);
        step();
        chk("mis_single", 32'(out_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1000;
        step();
        redirect_valid = 1'b0;
        chk("rec_halt", 32'(fetch_halted), 32'd0);
        step();
        chk("rec_pc", out_pc, 32'h1000);
        chk("rec_fault", 32'(out_fault), 32'd0);
        chk("rec_ins", out_ins, prog_words[0]);
        step();
        chk("rec_pc2", out_pc, 32'h1004);
        chk("rec_ins2", out_ins, prog_words[1]);

        // Write idx 5 in the cycle it is fetched
        base_we        = 1'b1;
        base_in        = 32'h0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h14;
        step();
        base_we        = 1'b0;
        redirect_valid = 1'b0;
        prog_we        = 1'b1;
        prog_addr      = 7'd5;
        prog_data      = 32'hDEAD_BEEF;
        step();
        prog_we = 1'b0;
        chk("wr_old_pc", out_pc, 32'h14);
        chk("wr_old_ins", out_ins, NOP);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h14;
        step();
        redirect_valid = 1'b0;
        step();
        chk("wr_new_pc", out_pc, 32'h14);
        chk("wr_new_ins", out_ins, 32'hDEAD_BEEF);

        // Reset mid-stream; memory survives
        rst = 1'b1;
        step();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_pc", out_pc, 32'h0);
        chk("post_rst_ins", out_ins, prog_words[0]);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h14;
        step();
        redirect_valid = 1'b0;
        step();
        chk("keep_pc", out_pc, 32'h14);
        chk("keep_ins", out_ins, 32'hDEAD_BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
